// File: rtl/flow_stats_pkg.sv
// Shared types for the flow statistics poller.
//   poll_state_t : sweep controller states
//   stat_entry_t : one exported statistic {flow, sum, last} at default widths
//   cnt_width()  : width needed to hold a counter value 0..max_val
package flow_stats_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ADV  = 2'd3
  } poll_state_t;

  localparam int FLOW_W = 10;
  localparam int SUM_W  = 32;

  typedef struct packed {
    logic [FLOW_W-1:0] flow;
    logic [SUM_W-1:0]  sum;
    logic              last;
  } stat_entry_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int TIMEOUT_DEF = 15;
  localparam int TIMEOUT_W   = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/stats_fifo.sv
// First-word-fall-through synchronous FIFO of statistic entries.
// Ports:
//   clk_i, rst_i      clock, async active-high reset (flushes pointers/count)
//   push_i, data_i    write side; a push into a full FIFO is accepted only
//                     together with a pop
//   pop_i, data_o     read side; data_o is the current head (stale when empty)
//   count_o           number of stored entries
//   full_o, empty_o   occupancy flags
module stats_fifo
  import flow_stats_pkg::*;
#(
  parameter type T     = stat_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // The slot being read this cycle may be rewritten at the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/flow_stats_poller.sv
// Sweeps every flow of the per-flow accumulator, issuing one read-and-clear
// strobe per flow and queueing {flow, sum, last} for the stats export path.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   start_i                          start a sweep (ignored unless idle)
//   busy_o, done_o, timeout_o        sweep status, completion and per-flow
//                                    timeout pulses
//   rd_stb_o, rd_flow_num_o          request to the accumulator
//   rd_data_i, rd_data_val_i         response from the accumulator
//   st_valid_o, st_ready_i           export handshake
//   st_flow_o, st_sum_o, st_last_o   export payload (zero while empty)
//
// state | meaning
// IDLE  | no sweep; waits for start_i
// REQ   | waits for a free FIFO slot, then strobes the current flow
// WAIT  | waits for the response or the timeout
// ADV   | finishes the sweep or moves to the next flow
module flow_stats_poller
  import flow_stats_pkg::*;
#(
  parameter int A_WIDTH    = 10,
  parameter int D_WIDTH    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic               rd_stb_o,
  output logic [A_WIDTH-1:0] rd_flow_num_o,
  input  logic [D_WIDTH-1:0] rd_data_i,
  input  logic               rd_data_val_i,
  output logic               st_valid_o,
  input  logic               st_ready_i,
  output logic [A_WIDTH-1:0] st_flow_o,
  output logic [D_WIDTH-1:0] st_sum_o,
  output logic               st_last_o
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [A_WIDTH-1:0] FLOW_MAX = '1;

  typedef struct packed {
    logic [A_WIDTH-1:0] flow;
    logic [D_WIDTH-1:0] sum;
    logic               last;
  } entry_t;

  poll_state_t        state_q;
  logic [A_WIDTH-1:0] flow_q;
  logic [TW-1:0]      wait_q;
  logic               busy_q;
  logic               done_q;
  logic               timeout_q;
  logic               rd_stb_q;

  logic     capture;
  logic     expire;
  logic     push;
  logic     slot_free;
  entry_t   wr_entry;
  entry_t   head;
  logic [CW:0] fifo_count;
  logic     fifo_empty;
  logic     fifo_full_unused;

  // The response line is not trusted during the strobe cycle itself.
  assign capture   = (state_q == WAIT) && rd_data_val_i && !rd_stb_q;
  // Expiry is decided one cycle early so timeout_o lands exactly TIMEOUT
  // cycles after the strobe.
  assign expire    = (state_q == WAIT) && !capture && (wait_q == TW'(TIMEOUT - 1));
  assign push      = capture || expire;
  assign slot_free = (fifo_count < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    wr_entry      = '0;
    wr_entry.flow = flow_q;
    wr_entry.sum  = capture ? rd_data_i : '0;
    wr_entry.last = (flow_q == FLOW_MAX);
  end

  stats_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (st_ready_i),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      flow_q    <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      rd_stb_q  <= 1'b0;
    end else begin
      rd_stb_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q high means the sweep has only just ended; a start here
          // belongs to the old sweep and is dropped.
          if (start_i && !done_q) begin
            state_q <= REQ;
            flow_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (slot_free) begin
            rd_stb_q <= 1'b1;
            wait_q   <= '0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (capture) begin
            state_q <= ADV;
          end else if (expire) begin
            timeout_q <= 1'b1;
            state_q   <= ADV;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ADV: begin
          if (flow_q == FLOW_MAX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            flow_q  <= flow_q + 1'b1;
            state_q <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign rd_stb_o      = rd_stb_q;
  assign rd_flow_num_o = flow_q;

  assign st_valid_o = !fifo_empty;
  assign st_flow_o  = fifo_empty ? '0 : head.flow;
  assign st_sum_o   = fifo_empty ? '0 : head.sum;
  assign st_last_o  = fifo_empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_flow_stats_poller.sv
module tb_flow_stats_poller;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, timeout_o, rd_stb_o;
  logic [1:0]  rd_flow_num_o;
  logic [31:0] rd_data_i = '0;
  logic        rd_data_val_i = 1'b0;
  logic        st_valid_o;
  logic        st_ready_i = 1'b1;
  logic [1:0]  st_flow_o;
  logic [31:0] st_sum_o;
  logic        st_last_o;

  always #5 clk = ~clk;

  flow_stats_poller #(
    .A_WIDTH(2), .D_WIDTH(32), .FIFO_DEPTH(2), .TIMEOUT(15)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .rd_stb_o(rd_stb_o), .rd_flow_num_o(rd_flow_num_o),
    .rd_data_i(rd_data_i), .rd_data_val_i(rd_data_val_i),
    .st_valid_o(st_valid_o), .st_ready_i(st_ready_i),
    .st_flow_o(st_flow_o), .st_sum_o(st_sum_o), .st_last_o(st_last_o)
  );

  // accumulator model: response 4 cycles after the strobe cycle
  logic [31:0] acc_mem [4];
  logic        pv [5];
  logic [1:0]  pf [5];
  int          no_resp_flow = -1;
  bit          cont_val = 1'b0;

  initial begin
    for (int i = 0; i < 5; i++) begin pv[i] = 1'b0; pf[i] = '0; end
  end

  always @(negedge clk) begin
    for (int i = 4; i > 0; i--) begin pv[i] = pv[i-1]; pf[i] = pf[i-1]; end
    pv[0] = rd_stb_o;
    pf[0] = rd_flow_num_o;
    if (cont_val) begin
      rd_data_val_i = 1'b1;
      rd_data_i     = rd_stb_o ? 32'hBAD : 32'd100 + 32'(rd_flow_num_o);
    end else if (pv[4] && int'(pf[4]) != no_resp_flow) begin
      rd_data_val_i = 1'b1;
      rd_data_i     = acc_mem[pf[4]];
    end else begin
      rd_data_val_i = 1'b0;
      rd_data_i     = '0;
    end
  end

  // monitors
  int         cyc = 0;
  logic [1:0] bf [$];
  logic [31:0] bs [$];
  logic       bl [$];
  int         bc [$];
  int         n_stb = 0;
  int         stb_cyc [$];
  logic [1:0] stb_flow [$];
  int         n_done = 0;
  int         done_cyc = 0;
  int         n_tmo = 0;
  int         tmo_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (st_valid_o && st_ready_i) begin
      bf.push_back(st_flow_o); bs.push_back(st_sum_o);
      bl.push_back(st_last_o); bc.push_back(cyc);
    end
    if (rd_stb_o) begin
      n_stb++; stb_cyc.push_back(cyc); stb_flow.push_back(rd_flow_num_o);
    end
    if (done_o) begin n_done++; done_cyc = cyc; end
    if (timeout_o) begin n_tmo++; tmo_cyc = cyc; end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(1); start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (n_done == d0 && n < 2000) begin tick(1); n++; end
    chk({tag, "_done_cnt"}, 64'(n_done - d0), 64'd1);
  endtask

  task automatic chk_beats(input string tag, input int b0,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_nbeats"}, 64'(bf.size() - b0), 64'd4);
    if (bf.size() - b0 >= 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s_flow%0d", tag, i), 64'(bf[b0+i]), 64'(i));
        chk($sformatf("%s_sum%0d", tag, i),  64'(bs[b0+i]), 64'(e[i]));
        chk($sformatf("%s_last%0d", tag, i), 64'(bl[b0+i]), 64'(i == 3));
      end
  endtask

  task automatic chk_strobes(input string tag, input int s0);
    chk({tag, "_nstb"}, 64'(n_stb - s0), 64'd4);
    if (n_stb - s0 >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_stbflow%0d", tag, i), 64'(stb_flow[s0+i]), 64'(i));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  64'(busy_o), 64'd0);
    chk({tag, "_done"},  64'(done_o), 64'd0);
    chk({tag, "_tmo"},   64'(timeout_o), 64'd0);
    chk({tag, "_stb"},   64'(rd_stb_o), 64'd0);
    chk({tag, "_rflow"}, 64'(rd_flow_num_o), 64'd0);
    chk({tag, "_valid"}, 64'(st_valid_o), 64'd0);
    chk({tag, "_sflow"}, 64'(st_flow_o), 64'd0);
    chk({tag, "_ssum"},  64'(st_sum_o), 64'd0);
    chk({tag, "_slast"}, 64'(st_last_o), 64'd0);
  endtask

  initial begin
    int b0, s0, d0, t0, n;
    acc_mem[0] = 32'd5; acc_mem[1] = 32'd7; acc_mem[2] = 32'd0; acc_mem[3] = 32'd9;

    // reset state
    tick(3);
    chk_quiet("rst");
    rst_i = 1'b0;
    tick(2);

    // basic sweep, no backpressure
    b0 = bf.size(); s0 = n_stb; d0 = n_done; t0 = n_tmo;
    pulse_start();
    chk("basic_busy_after_start", 64'(busy_o), 64'd1);
    wait_done("basic", d0);
    tick(3);
    chk_beats("basic", b0, 5, 7, 0, 9);
    chk_strobes("basic", s0);
    chk("basic_no_tmo", 64'(n_tmo - t0), 64'd0);
    if (bc.size() - b0 >= 4)
      chk("basic_done_after_last", 64'(done_cyc - bc[b0+3]), 64'd1);
    chk("basic_busy_end", 64'(busy_o), 64'd0);
    chk("basic_ndone_end", 64'(n_done - d0), 64'd1);

    // backpressure: depth 2, ready low for 20 cycles
    st_ready_i = 1'b0;
    b0 = bf.size(); s0 = n_stb; d0 = n_done;
    pulse_start();
    tick(19);
    chk("bp_stall_nstb", 64'(n_stb - s0), 64'd2);
    chk("bp_stall_valid", 64'(st_valid_o), 64'd1);
    chk("bp_stall_head", 64'(st_flow_o), 64'd0);
    chk("bp_stall_busy", 64'(busy_o), 64'd1);
    st_ready_i = 1'b1;
    wait_done("bp", d0);
    tick(3);
    chk_beats("bp", b0, 5, 7, 0, 9);
    chk_strobes("bp", s0);

    // no response for flow 1
    no_resp_flow = 1;
    b0 = bf.size(); s0 = n_stb; d0 = n_done; t0 = n_tmo;
    pulse_start();
    wait_done("tmo", d0);
    tick(3);
    chk("tmo_count", 64'(n_tmo - t0), 64'd1);
    if (stb_cyc.size() - s0 >= 2)
      chk("tmo_delay", 64'(tmo_cyc - stb_cyc[s0+1]), 64'd15);
    chk_beats("tmo", b0, 5, 0, 0, 9);
    no_resp_flow = -1;

    // response valid held high
    cont_val = 1'b1;
    b0 = bf.size(); s0 = n_stb; d0 = n_done; t0 = n_tmo;
    pulse_start();
    wait_done("cval", d0);
    tick(3);
    chk_beats("cval", b0, 100, 101, 102, 103);
    chk_strobes("cval", s0);
    chk("cval_no_tmo", 64'(n_tmo - t0), 64'd0);
    cont_val = 1'b0;
    tick(8);

    // reset while waiting for flow 2
    st_ready_i = 1'b0;
    s0 = n_stb; d0 = n_done;
    pulse_start();
    n = 0;
    while (n_stb - s0 < 2 && n < 200) begin tick(1); n++; end
    st_ready_i = 1'b1; tick(1); st_ready_i = 1'b0;
    n = 0;
    while (n_stb - s0 < 3 && n < 200) begin tick(1); n++; end
    chk("mid_stb_flow2", 64'(rd_flow_num_o), 64'd2);
    tick(1);
    chk("mid_valid_before", 64'(st_valid_o), 64'd1);
    chk("mid_head_before", 64'(st_flow_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk_quiet("mid_rst");
    tick(2);
    rst_i = 1'b0;
    tick(30);
    chk("mid_no_done", 64'(n_done - d0), 64'd0);
    chk("mid_idle_busy", 64'(busy_o), 64'd0);

    st_ready_i = 1'b1;
    b0 = bf.size(); s0 = n_stb; d0 = n_done;
    pulse_start();
    wait_done("restart", d0);
    tick(3);
    chk_beats("restart", b0, 5, 7, 0, 9);
    chk_strobes("restart", s0);

    // second start while busy
    b0 = bf.size(); s0 = n_stb; d0 = n_done;
    pulse_start();
    tick(5);
    pulse_start();
    wait_done("dbl", d0);
    tick(20);
    chk("dbl_ndone", 64'(n_done - d0), 64'd1);
    chk_beats("dbl", b0, 5, 7, 0, 9);
    chk_strobes("dbl", s0);

    // start coinciding with done_o
    d0 = n_done;
    pulse_start();
    n = 0;
    while (!done_o && n < 2000) begin tick(1); n++; end
    chk("cdone_seen", 64'(done_o), 64'd1);
    s0 = n_stb;
    start_i = 1'b1; tick(1); start_i = 1'b0;
    chk("cdone_busy", 64'(busy_o), 64'd0);
    tick(10);
    chk("cdone_no_stb", 64'(n_stb - s0), 64'd0);
    chk("cdone_ndone", 64'(n_done - d0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
